// File: rtl/instr_mem_prog_if.sv
// rtl/instr_mem_prog_if.sv - fetch and programming port bundle for instr_mem_prog
//
// master: the core/loader side, drives fetch and program-write requests
// slave : the instruction memory, returns instru/instru_valid/addr_fault,
//         prog_err and init_done
interface instr_mem_prog_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instru;
  logic              instru_valid;
  logic              addr_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;
  logic              init_done;

  modport master (
    output fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
    input  instru, instru_valid, addr_fault, prog_err, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
    output instru, instru_valid, addr_fault, prog_err, init_done
  );
endinterface

// File: rtl/instr_mem_prog.sv
// rtl/instr_mem_prog.sv - writable instruction memory with NOP init sequencer
//
// clk   : system clock, rising edge
// reset : synchronous active-high; restarts the NOP fill from word 0
// bus   : slave side of instr_mem_prog_if
//         fetch_req/fetch_addr -> instru/instru_valid/addr_fault (1-cycle registered read)
//         prog_we/prog_addr/prog_data -> prog_err (write lands on the sampling edge)
//         init_done high once every word holds NOP_WORD
module instr_mem_prog #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter int                 DEPTH    = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input logic             clk,
  input logic             reset,
  instr_mem_prog_if.slave bus
);

  // Comparisons are done one bit wider than the address so that
  // DEPTH = 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fetch_en;
  logic              fetch_oob;
  logic              prog_rej;
  logic              prog_oob;

  assign fetch_oob = {1'b0, bus.fetch_addr} >= DEPTH_W;
  assign prog_oob  = {1'b0, bus.prog_addr}  >= DEPTH_W;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + PTR_ONE;
      if (ptr_q == LAST_PTR) begin
        state_d = S_RUN;
      end
    end
  end

  // Output/datapath control: INIT owns the write port, RUN hands it to
  // the programming interface.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.prog_addr;
    mem_wdata = bus.prog_data;
    fetch_en  = 1'b0;
    prog_rej  = 1'b0;
    if (!reset) begin
      if (state_q == S_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q[ADDR_W-1:0];
        mem_wdata = NOP_WORD;
        prog_rej  = bus.prog_we;
      end else begin
        fetch_en  = bus.fetch_req;
        mem_we    = bus.prog_we && !prog_oob;
        prog_rej  = bus.prog_we && prog_oob;
      end
    end
  end

  assign bus.init_done = (state_q == S_RUN);

  // Array write; the read below uses the pre-edge contents, which gives
  // read-first behaviour on a same-address fetch/write collision.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instru       <= NOP_WORD;
      bus.instru_valid <= 1'b0;
      bus.addr_fault   <= 1'b0;
      bus.prog_err     <= 1'b0;
    end else begin
      bus.instru_valid <= fetch_en;
      bus.addr_fault   <= fetch_en && fetch_oob;
      bus.prog_err     <= prog_rej;
      if (fetch_en) begin
        bus.instru <= fetch_oob ? NOP_WORD : mem[bus.fetch_addr];
      end
    end
  end

endmodule
